rr_arbiter_wslice: RTL and testbench

RR_ARBITER_WSLICE -- requirements
Module: rr_arbiter_wslice

---
 rtl/rr_arbiter_wslice.sv | 153 +++++++++++++++
 tb/tb_rr_arbiter_wslice.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rr_arbiter_wslice.sv
// Round-robin arbiter with a per-requester time slice (quantum).
// Every output is registered, so there is no combinational path from req to gnt.
module rr_arbiter_wslice #(
    parameter int N  = 4,
    parameter int CW = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic [N*CW-1:0] slice_len,
    output logic [N-1:0]    gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            gnt_valid,
    output logic            slice_end
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   id_q, id_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   qlen_q, qlen_d;
    logic            gv_q, gv_d;
    logic            se_q, se_d;

    logic            do_start;
    logic            go_idle;
    logic [IW-1:0]   nh;
    logic [IW:0]     srch;

    // Returns {found, index} of the first set mask bit, scanning start, start+1, ... mod N.
    function automatic logic [IW:0] search(input logic [IW-1:0] start, input logic [N-1:0] mask);
        logic [IW:0] r;
        int          j;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start) + k) % N;
            if (mask[j]) r = {1'b1, IW'(j)};
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] h);
        return IW'((int'(h) + 1) % N);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // A zero-length quantum would never expire; treat it as one cycle.
    function automatic logic [CW-1:0] fix_len(input logic [CW-1:0] f);
        return (f == '0) ? CW'(1) : f;
    endfunction

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        qlen_d   = qlen_q;
        do_start = 1'b0;
        go_idle  = 1'b0;
        nh       = id_q;
        srch     = '0;

        if (!en) begin
            go_idle = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    srch = search(ptr_q, req);
                    if (srch[IW]) begin
                        do_start = 1'b1;
                        nh       = srch[IW-1:0];
                    end
                end
                GRANT: begin
                    // Candidates for handover always exclude the current holder.
                    srch = search(nxt_idx(id_q), req & ~onehot(id_q));
                    if (!req[id_q]) begin
                        if (srch[IW]) begin
                            do_start = 1'b1;
                            nh       = srch[IW-1:0];
                        end else begin
                            go_idle = 1'b1;
                        end
                    end else if (cnt_q != qlen_q - CW'(1)) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        do_start = 1'b1;
                        nh       = srch[IW] ? srch[IW-1:0] : id_q;
                    end
                end
                default: go_idle = 1'b1;
            endcase
        end

        if (go_idle) begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            cnt_d   = '0;
        end else if (do_start) begin
            state_d = GRANT;
            gnt_d   = onehot(nh);
            id_d    = nh;
            cnt_d   = '0;
            qlen_d  = fix_len(slice_len[nh*CW +: CW]);
            ptr_d   = nxt_idx(nh);
        end

        gv_d = |gnt_d;
        // Registered look-ahead: flag is high during the cycle whose count is the quantum's last.
        se_d = (state_d == GRANT) && (cnt_d == qlen_d - CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            qlen_q  <= '0;
            gv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            qlen_q  <= qlen_d;
            gv_q    <= gv_d;
            se_q    <= se_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = gv_q;
    assign slice_end = se_q;

endmodule

// File: tb/tb_rr_arbiter_wslice.sv
// Directed bench for rr_arbiter_wslice (N=4, CW=4) with hand-computed expected grants.
module tb_rr_arbiter_wslice;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  req;
    logic [15:0] slice_len;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_valid;
    logic        slice_end;

    int n_chk  = 0;
    int n_fail = 0;

    rr_arbiter_wslice #(.N(4), .CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .slice_len (slice_len),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .slice_end (slice_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                           input logic ese);
        chk({tag, ".gnt"},       32'(gnt),       32'(eg));
        chk({tag, ".gnt_id"},    32'(gnt_id),    32'(eid));
        chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(|eg));
        chk({tag, ".slice_end"}, 32'(slice_end), 32'(ese));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Equal quanta of 2 with all requesting.
    logic [3:0] a_g  [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [1:0] a_id [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    logic       a_se [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // Lone requester 2 with a quantum of 3.
    logic       b_se [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    // Requester 1 with zero-length quantum alternating against requester 0.
    logic [3:0] d_g  [7] = '{4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0010};
    logic [1:0] d_id [7] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
    logic       d_se [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        req       = 4'b0000;
        slice_len = 16'h0000;
        #2;
        chk_out("reset", 4'b0000, 2'd0, 1'b0);

        @(negedge clk);
        rst_n     = 1'b1;
        en        = 1'b1;
        req       = 4'b1111;
        slice_len = 16'h2222;
        for (int i = 0; i < 9; i++) begin
            step();
            chk_out($sformatf("rr_all[%0d]", i), a_g[i], a_id[i], a_se[i]);
        end

        req       = 4'b0100;
        slice_len = 16'h2322;
        for (int i = 0; i < 7; i++) begin
            step();
            chk_out($sformatf("single[%0d]", i), 4'b0100, 2'd2, b_se[i]);
        end

        req = 4'b0000;
        step();
        chk_out("to_idle", 4'b0000, 2'd0, 1'b0);
        req       = 4'b0001;
        slice_len = 16'h2325;
        step();
        chk_out("drop_c0", 4'b0001, 2'd0, 1'b0);
        step();
        chk_out("drop_c1", 4'b0001, 2'd0, 1'b0);
        req = 4'b1010;
        step();
        chk_out("drop_next", 4'b0010, 2'd1, 1'b0);

        req       = 4'b0011;
        slice_len = 16'h2302;
        for (int i = 0; i < 7; i++) begin
            step();
            chk_out($sformatf("zero_len[%0d]", i), d_g[i], d_id[i], d_se[i]);
        end

        req       = 4'b0100;
        slice_len = 16'h2222;
        step();
        chk_out("en_hold2", 4'b0100, 2'd2, 1'b0);
        en = 1'b0;
        step();
        chk_out("en_off", 4'b0000, 2'd0, 1'b0);
        en  = 1'b1;
        req = 4'b0101;
        step();
        chk_out("en_back", 4'b0001, 2'd0, 1'b0);

        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 2'd0, 1'b0);
        #2;
        rst_n = 1'b1;
        req   = 4'b1000;
        #1;
        chk_out("rst_released", 4'b0000, 2'd0, 1'b0);
        step();
        chk_out("post_rst_c0", 4'b1000, 2'd3, 1'b0);
        step();
        chk_out("post_rst_c1", 4'b1000, 2'd3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
